// File: rtl/comparador_sequencial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : comparador_sequencial (with helper comparador_2bits)
//  Purpose  : Sequential equality comparator for WIDTH-bit words. A single
//             2-bit slice comparator is stepped over the latched operands,
//             LSB slice first, one slice per clock, stopping at the first
//             mismatching slice. Start/ready/done handshake.
//  Ports    : clk, rst_n (async, active low)
//             start, abort           - control inputs
//             a, b [WIDTH-1:0]       - operands, latched on accepted start
//             ready, busy, done      - state decodes (IDLE, COMPARE, DONE)
//             equal, mismatch_idx    - result, updated on entry to DONE
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  comparador_2bits : combinational equality of two 2-bit slices.
//  Ports : i_a, i_b [1:0] slices ; o_eq = 1 when equal
// ----------------------------------------------------------------------------
module comparador_2bits (
   input  logic [1:0] i_a,
   input  logic [1:0] i_b,
   output logic       o_eq
);
   assign o_eq = (i_a == i_b);
endmodule

module comparador_sequencial #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [WIDTH-1:0]          a,
   input  logic [WIDTH-1:0]          b,
   output logic                      ready,
   output logic                      busy,
   output logic                      done,
   output logic                      equal,
   output logic [((WIDTH/2) > 1 ? $clog2(WIDTH/2) : 1)-1:0] mismatch_idx
);

   localparam int N  = WIDTH / 2;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] C_LAST_IDX = IW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   logic             r_equal;
   logic [IW-1:0]    r_mismatch_idx;

   logic [1:0]       w_slice_a;
   logic [1:0]       w_slice_b;
   logic             w_slice_eq;

   // Slice i occupies bits [2i+1:2i]; the index is never above N-1.
   assign w_slice_a = r_a[{r_idx, 1'b0} +: 2];
   assign w_slice_b = r_b[{r_idx, 1'b0} +: 2];

   comparador_2bits u_slice (
      .i_a  (w_slice_a),
      .i_b  (w_slice_b),
      .o_eq (w_slice_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_a            <= '0;
         r_b            <= '0;
         r_idx          <= '0;
         r_equal        <= 1'b0;
         r_mismatch_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_idx   <= '0;
                  r_state <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               // Abort has priority over any result of the current slice.
               if (abort) begin
                  r_state <= S_IDLE;
               end else if (!w_slice_eq) begin
                  r_equal        <= 1'b0;
                  r_mismatch_idx <= r_idx;
                  r_state        <= S_DONE;
               end else if (r_idx == C_LAST_IDX) begin
                  r_equal        <= 1'b1;
                  r_mismatch_idx <= '0;
                  r_state        <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs are pure decodes of the state register.
   assign ready        = (r_state == S_IDLE);
   assign busy         = (r_state == S_COMPARE);
   assign done         = (r_state == S_DONE);
   assign equal        = r_equal;
   assign mismatch_idx = r_mismatch_idx;

endmodule
`default_nettype wire

// File: tb/tb_comparador_sequencial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_comparador_sequencial
//  Purpose  : Self-checking bench for comparador_sequencial (WIDTH=8):
//             directed table, random vectors against a reference model,
//             and hand-written abort / reset / held-start sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_comparador_sequencial;

   localparam int W = 8;
   localparam int N = W / 2;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic         equal;
   logic [1:0]   mismatch_idx;

   int total = 0;
   int bad   = 0;

   comparador_sequencial #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .a            (a),
      .b            (b),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .equal        (equal),
      .mismatch_idx (mismatch_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         eq;
      logic [1:0]   idx;
      int           lat;
   } vec_t;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Reference: first differing 2-bit group of a^b decides everything.
   task automatic ref_cmp(input logic [W-1:0] ra, input logic [W-1:0] rb,
                          output logic eq, output logic [1:0] idx, output int lat);
      int d;
      d   = int'(ra ^ rb);
      eq  = 1'b1;
      idx = 2'd0;
      lat = N;
      for (int k = 0; k < N; k++) begin
         if (((d >> (2 * k)) & 3) != 0) begin
            eq  = 1'b0;
            idx = 2'(k);
            lat = k + 1;
            break;
         end
      end
   endtask

   // Issues one start, scrambles a/b afterwards, and measures latency
   // (edges after the accepting edge until done is seen) and busy cycles.
   task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input bit hold, output int lat, output int busy_cnt,
                         output int done_cnt);
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      @(posedge clk);
      lat = -1; busy_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         a = W'($urandom); b = W'($urandom);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            lat = c;
            break;
         end
      end
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] ta,
                                input logic [W-1:0] tb_v, input logic eq,
                                input logic [1:0] idx, input int lat);
      int l, bc, dc;
      do_cmp(ta, tb_v, 1'b0, l, bc, dc);
      check({name, ".lat"}, l, lat);
      check({name, ".busy"}, bc, lat);
      check({name, ".equal"}, int'(equal), int'(eq));
      check({name, ".idx"}, int'(mismatch_idx), int'(idx));
      @(negedge clk);
      check({name, ".ready_after"}, int'(ready), 1);
      check({name, ".done_once"}, int'(done), 0);
   endtask

   vec_t tbl[6];

   initial begin
      logic       m_eq;
      logic [1:0] m_idx;
      int         m_lat, l, bc, dc;
      logic [W-1:0] ra, rb;

      tbl[0] = '{8'hA5, 8'hA5, 1'b1, 2'd0, 4};
      tbl[1] = '{8'hA5, 8'hA4, 1'b0, 2'd0, 1};
      tbl[2] = '{8'hA5, 8'h25, 1'b0, 2'd3, 4};
      tbl[3] = '{8'h00, 8'h0C, 1'b0, 2'd1, 2};
      tbl[4] = '{8'hFF, 8'hCF, 1'b0, 2'd2, 3};
      tbl[5] = '{8'h3C, 8'h3C, 1'b1, 2'd0, 4};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
      #12;
      check("rst.ready", int'(ready), 1);
      check("rst.busy", int'(busy), 0);
      check("rst.done", int'(done), 0);
      check("rst.equal", int'(equal), 0);
      check("rst.idx", int'(mismatch_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 6; i++)
         run_and_check($sformatf("tbl%0d", i), tbl[i].va, tbl[i].vb,
                       tbl[i].eq, tbl[i].idx, tbl[i].lat);

      // Random vectors, biased towards near-equal operands
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = ra;
         if ($urandom_range(0, 3) != 0)
            rb = ra ^ W'($urandom_range(1, 3) << (2 * $urandom_range(0, N - 1)));
         if ($urandom_range(0, 5) == 0)
            rb = W'($urandom);
         ref_cmp(ra, rb, m_eq, m_idx, m_lat);
         run_and_check($sformatf("rnd%0d", i), ra, rb, m_eq, m_idx, m_lat);
      end

      // Held start with operand changes while busy: one done, E0 operands
      do_cmp(8'h5A, 8'h5A, 1'b1, l, bc, dc);
      check("hold.lat", l, 4);
      check("hold.done_cnt", dc, 1);
      check("hold.equal", int'(equal), 1);
      @(negedge clk);
      check("hold.ready", int'(ready), 1);
      check("hold.done_low", int'(done), 0);
      @(negedge clk);
      check("hold.reaccept", int'(busy), 1);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("hold.abort_idle", int'(ready), 1);

      // Establish a known previous result: mismatch at slice 2
      run_and_check("pre_abort", 8'h0F, 8'h2F, 1'b0, 2'd2, 3);

      // Abort at E2 of an equal compare
      @(negedge clk);
      a = 8'hA5; b = 8'hA5; start = 1'b1;
      @(posedge clk);              // E0
      @(negedge clk); start = 1'b0;
      @(negedge clk); abort = 1'b1; // high across E2
      @(negedge clk); abort = 1'b0;
      check("abort.ready", int'(ready), 1);
      check("abort.busy", int'(busy), 0);
      dc = 0;
      for (int c = 0; c < 6; c++) begin
         if (done) dc++;
         @(negedge clk);
      end
      check("abort.no_done", dc, 0);
      check("abort.equal_kept", int'(equal), 0);
      check("abort.idx_kept", int'(mismatch_idx), 2);

      // Abort in IDLE does nothing
      abort = 1'b1;
      @(negedge clk); @(negedge clk);
      abort = 1'b0;
      check("abort_idle.ready", int'(ready), 1);
      check("abort_idle.idx", int'(mismatch_idx), 2);

      // Abort on the same edge as a slice-0 mismatch: abort wins
      @(negedge clk);
      a = 8'hA5; b = 8'hA4; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; abort = 1'b1; // high across E1
      @(negedge clk); abort = 1'b0;
      check("abort_mm.done", int'(done), 0);
      check("abort_mm.ready", int'(ready), 1);
      check("abort_mm.idx", int'(mismatch_idx), 2);

      // Previous result with nonzero index, then async reset mid-compare
      run_and_check("pre_rst", 8'hA5, 8'h25, 1'b0, 2'd3, 4);
      @(negedge clk);
      a = 8'hA5; b = 8'hA5; start = 1'b1;
      @(posedge clk);              // E0
      @(negedge clk); start = 1'b0;
      @(posedge clk);              // E1
      @(posedge clk);              // E2
      #2 rst_n = 1'b0;
      #1;
      check("arst.ready", int'(ready), 1);
      check("arst.busy", int'(busy), 0);
      check("arst.done", int'(done), 0);
      check("arst.equal", int'(equal), 0);
      check("arst.idx", int'(mismatch_idx), 0);
      dc = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) dc++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) dc++;
      end
      check("arst.no_done", dc, 0);
      run_and_check("post_rst", 8'h96, 8'h86, 1'b0, 2'd2, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
